// File: rtl/st_sample_frame_capture_if.sv
// Avalon-ST sample stream carrying a prefixed channel: one sample per beat,
// with SOP/EOP delimiting a frame.
interface st_sample_frame_capture_if #(
  parameter int DATA_W = 12,
  parameter int CHAN_W = 7
);
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [CHAN_W-1:0] channel;
  logic              startofpacket;
  logic              endofpacket;

  modport master (input ready, output valid, data, channel, startofpacket, endofpacket);
  modport slave  (output ready, input valid, data, channel, startofpacket, endofpacket);
endinterface

// File: rtl/st_sample_frame_capture.sv
// Captures one ST packet per frame into a ping-pong per-channel sample table;
// a completed frame swaps banks so the reader sees a coherent snapshot.
module st_sample_frame_capture #(
  parameter int DATA_W = 12,
  parameter int CHAN_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  st_sample_frame_capture_if.slave STin,
  input  logic                 rd_lock,
  input  logic [CHAN_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_written,
  output logic                 frame_pulse,
  output logic [CNT_W-1:0]     frame_count,
  output logic [7:0]           err_count,
  output logic [CHAN_W:0]      frame_beats
);
  localparam int DEPTH = 2**CHAN_W;
  localparam logic [CHAN_W:0] BEAT_MAX = (CHAN_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   bank_q, bank_d;
  logic [1:0][DEPTH-1:0]  mask_q, mask_d;
  logic [CHAN_W:0]        beats_q, beats_d;
  logic [CHAN_W:0]        frame_beats_q, frame_beats_d;
  logic [CNT_W-1:0]       frame_count_q, frame_count_d;
  logic [7:0]             err_count_q, err_count_d;
  logic                   frame_pulse_q, frame_pulse_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   rd_written_q, rd_written_d;
  logic                   rd_zero_q;
  logic                   xfer, wr_en, complete, swap, err_inc;
  logic [DEPTH-1:0]       ch_onehot;
  logic [DATA_W-1:0]      rd_word [2];

  assign STin.ready = ~reset & (state_q != HOLD);
  assign xfer       = STin.valid & STin.ready;
  assign ch_onehot  = DEPTH'(1) << STin.channel;

  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    mask_d        = mask_q;
    beats_d       = beats_q;
    frame_beats_d = frame_beats_q;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    frame_pulse_d = 1'b0;
    wr_en         = 1'b0;
    complete      = 1'b0;
    swap          = 1'b0;
    err_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (STin.startofpacket) begin
            wr_en          = 1'b1;
            mask_d[bank_q] = ch_onehot;
            beats_d        = (CHAN_W+1)'(1);
            state_d        = CAPTURE;
            complete       = STin.endofpacket;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (xfer) begin
          wr_en = 1'b1;
          // A mid-frame SOP restarts the frame: prior slots of this frame are forgotten.
          if (STin.startofpacket) begin
            mask_d[bank_q] = ch_onehot;
            beats_d        = (CHAN_W+1)'(1);
            err_inc        = 1'b1;
          end else begin
            mask_d[bank_q] = mask_q[bank_q] | ch_onehot;
            if (beats_q != BEAT_MAX) beats_d = beats_q + (CHAN_W+1)'(1);
          end
          complete = STin.endofpacket;
        end
      end
      HOLD:    swap = ~rd_lock;
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (rd_lock) state_d = HOLD;
      else         swap    = 1'b1;
    end

    if (swap) begin
      bank_d        = ~bank_q;
      frame_pulse_d = 1'b1;
      frame_count_d = frame_count_q + CNT_W'(1);
      frame_beats_d = beats_d;
      state_d       = IDLE;
    end

    if (err_inc && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

    // Read samples the bank that is the snapshot before this edge's swap.
    rd_sel_d     = ~bank_q;
    rd_written_d = mask_q[~bank_q][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bank_q        <= 1'b0;
      mask_q        <= '0;
      beats_q       <= '0;
      frame_beats_q <= '0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      frame_pulse_q <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_written_q  <= 1'b0;
      rd_zero_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      mask_q        <= mask_d;
      beats_q       <= beats_d;
      frame_beats_q <= frame_beats_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      frame_pulse_q <= frame_pulse_d;
      rd_sel_q      <= rd_sel_d;
      rd_written_q  <= rd_written_d;
      rd_zero_q     <= 1'b0;
    end
  end

  // One simple dual-port RAM per bank with a registered read.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_word_q;
      always_ff @(posedge clk) begin
        if (wr_en && (bank_q == 1'(gi))) mem[STin.channel] <= STin.data;
        rd_word_q <= mem[rd_addr];
      end
      assign rd_word[gi] = rd_word_q;
    end
  endgenerate

  assign rd_data     = rd_zero_q ? '0 : rd_word[rd_sel_q];
  assign rd_written  = rd_written_q;
  assign frame_pulse = frame_pulse_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign frame_beats = frame_beats_q;
endmodule

// File: tb/tb_st_sample_frame_capture.sv
// Directed plus randomized bench; a frame-list reference model predicts every output each cycle.
module tb_st_sample_frame_capture;
  localparam int DATA_W = 12;
  localparam int CHAN_W = 7;
  localparam int CNT_W  = 2;
  localparam int DEPTH  = 2**CHAN_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_lock = 1'b0;
  logic [CHAN_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_written;
  logic              frame_pulse;
  logic [CNT_W-1:0]  frame_count;
  logic [7:0]        err_count;
  logic [CHAN_W:0]   frame_beats;

  st_sample_frame_capture_if #(.DATA_W(DATA_W), .CHAN_W(CHAN_W)) st_if ();

  st_sample_frame_capture #(.DATA_W(DATA_W), .CHAN_W(CHAN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .STin        (st_if),
    .rd_lock     (rd_lock),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_written  (rd_written),
    .frame_pulse (frame_pulse),
    .frame_count (frame_count),
    .err_count   (err_count),
    .frame_beats (frame_beats)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the frame is a list of (channel, data) beats; the snapshot is rebuilt from it.
  bit m_in_frame, m_pending;
  int q_ch[$];
  int q_dat[$];
  int snap_dat[DEPTH];
  bit snap_wr[DEPTH];
  int m_frames, m_errs, m_beats;
  bit e_pulse, e_rdw, e_rdd_chk;
  int e_rdd;
  bit acc_last;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_err();
    if (m_errs < 255) m_errs++;
  endtask

  task automatic publish();
    foreach (snap_wr[i]) snap_wr[i] = 1'b0;
    for (int i = 0; i < q_ch.size(); i++) begin
      snap_dat[q_ch[i]] = q_dat[i];
      snap_wr[q_ch[i]]  = 1'b1;
    end
    m_beats   = (q_ch.size() > DEPTH) ? DEPTH : q_ch.size();
    m_frames++;
    e_pulse   = 1'b1;
    m_pending = 1'b0;
    $display("frame %0d published beats=%0d", m_frames, m_beats);
  endtask

  task automatic model_step(bit r, bit acc, int ch, int d, bit s, bit e, bit lk, int a);
    e_pulse = 1'b0;
    if (r) begin
      m_in_frame = 1'b0;
      m_pending  = 1'b0;
      q_ch.delete();
      q_dat.delete();
      foreach (snap_wr[i]) snap_wr[i] = 1'b0;
      m_frames = 0; m_errs = 0; m_beats = 0;
      e_rdw = 1'b0; e_rdd = 0; e_rdd_chk = 1'b1;
      return;
    end
    e_rdw     = snap_wr[a];
    e_rdd     = snap_dat[a];
    e_rdd_chk = snap_wr[a];
    if (m_pending) begin
      if (!lk) publish();
    end else if (acc) begin
      $display("beat ch=0x%02h data=0x%03h sop=%0d eop=%0d", ch, d, s, e);
      if (s) begin
        if (m_in_frame) bump_err();
        q_ch.delete();
        q_dat.delete();
        m_in_frame = 1'b1;
      end
      if (m_in_frame) begin
        q_ch.push_back(ch);
        q_dat.push_back(d);
        if (e) begin
          m_in_frame = 1'b0;
          if (lk) m_pending = 1'b1;
          else    publish();
        end
      end else begin
        bump_err();
      end
    end
  endtask

  task automatic cycle();
    bit exp_ready, v, s, e, lk, r;
    int ch, d, a;
    #1;
    exp_ready = !reset && !m_pending;
    check("ready", st_if.ready, exp_ready);
    v = st_if.valid; s = st_if.startofpacket; e = st_if.endofpacket;
    ch = st_if.channel; d = st_if.data; lk = rd_lock; r = reset; a = rd_addr;
    acc_last = v && exp_ready;
    @(posedge clk);
    model_step(r, acc_last, ch, d, s, e, lk, a);
    #1;
    check("frame_pulse", frame_pulse, e_pulse);
    check("frame_count", frame_count, m_frames % (1 << CNT_W));
    check("err_count", err_count, m_errs);
    check("frame_beats", frame_beats, m_beats);
    check("rd_written", rd_written, e_rdw);
    if (e_rdd_chk) check("rd_data", rd_data, e_rdd);
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic beat(int ch, int d, bit s, bit e);
    int n = 0;
    st_if.valid = 1'b1;
    st_if.channel = ch[CHAN_W-1:0];
    st_if.data = d[DATA_W-1:0];
    st_if.startofpacket = s;
    st_if.endofpacket = e;
    do begin
      if (n >= 8) rd_lock = 1'b0;
      cycle();
      n++;
    end while (!acc_last && n < 32);
    st_if.valid = 1'b0;
    st_if.startofpacket = 1'b0;
    st_if.endofpacket = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    st_if.valid = 1'b0;
    st_if.data = '0;
    st_if.channel = '0;
    st_if.startofpacket = 1'b0;
    st_if.endofpacket = 1'b0;

    // Reset state
    idle(2);
    check("rst_ready", st_if.ready, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_beats", frame_beats, 0);
    reset = 1'b0;
    idle(1);

    // Single frame
    beat(7'h10, 12'h123, 1, 0);
    beat(7'h45, 12'hABC, 0, 0);
    beat(7'h7F, 12'hFFF, 0, 1);
    check("sf_pulse", frame_pulse, 1);
    check("sf_count", frame_count, 1);
    check("sf_beats", frame_beats, 3);
    rd_addr = 7'h45;
    idle(1);
    check("sf_rd45_data", rd_data, 12'hABC);
    check("sf_rd45_wr", rd_written, 1);
    rd_addr = 7'h00;
    idle(1);
    check("sf_rd00_wr", rd_written, 0);

    // Lock back-pressure
    rd_lock = 1'b1;
    beat(7'h03, 12'h111, 1, 0);
    beat(7'h09, 12'h222, 0, 1);
    rd_addr = 7'h45;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("hold_ready", st_if.ready, 0);
      check("hold_pulse", frame_pulse, 0);
    end
    check("hold_old_snap", rd_data, 12'hABC);
    rd_lock = 1'b0;
    idle(1);
    check("unlock_pulse", frame_pulse, 1);
    check("unlock_ready", st_if.ready, 1);
    check("unlock_beats", frame_beats, 2);

    // Framing errors
    beat(7'h20, 12'h005, 0, 0);
    check("err_orphan", err_count, 1);
    beat(7'h21, 12'h006, 1, 0);
    beat(7'h22, 12'h007, 0, 0);
    beat(7'h23, 12'h008, 1, 0);
    check("err_restart", err_count, 2);
    beat(7'h24, 12'h009, 1, 1);
    check("err_sopeop", err_count, 3);
    check("err_beats", frame_beats, 1);
    rd_addr = 7'h21;
    idle(1);
    check("err_rd21_wr", rd_written, 0);
    rd_addr = 7'h24;
    idle(1);
    check("err_rd24_data", rd_data, 12'h009);

    // Ping-pong
    do_reset();
    rd_addr = 7'h05;
    beat(7'h05, 12'h001, 1, 0);
    beat(7'h06, 12'h0A0, 0, 1);
    idle(1);
    check("pp_f1", rd_data, 12'h001);
    beat(7'h05, 12'h002, 1, 0);
    beat(7'h07, 12'h0B0, 0, 1);
    check("pp_swap_read", rd_data, 12'h001);
    check("pp_count", frame_count, 2);
    idle(1);
    check("pp_f2", rd_data, 12'h002);

    // Reset mid-frame
    beat(7'h01, 12'h0C1, 1, 0);
    beat(7'h02, 12'h0C2, 0, 0);
    reset = 1'b1;
    idle(1);
    check("rmf_ready", st_if.ready, 0);
    check("rmf_count", frame_count, 0);
    check("rmf_rd_wr", rd_written, 0);
    reset = 1'b0;
    beat(7'h01, 12'h055, 1, 0);
    beat(7'h02, 12'h066, 0, 1);
    check("rmf_new_count", frame_count, 1);
    rd_addr = 7'h02;
    idle(1);
    check("rmf_rd02", rd_data, 12'h066);

    // Saturation and wrap
    for (int i = 0; i < 300; i++) beat(i % DEPTH, i, 0, 0);
    check("err_sat", err_count, 255);
    do_reset();
    for (int i = 0; i < 5; i++) beat(i, 12'h100 + i, 1, 1);
    check("cnt_wrap", frame_count, 1);

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      rd_addr = 7'($urandom_range(0, 15));
      rd_lock = ($urandom_range(0, 3) == 0);
      beat($urandom_range(0, 15), $urandom_range(0, 4095),
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rd_lock = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
